// File: rtl/ir_key_pkg.sv
`default_nettype none
//==============================================================================
// Module      : ir_key_pkg
// Description : Shared definitions for the IR key event block: event type
//               codes, evt_data field positions, FSM state encoding and a
//               helper that packs an event byte.
// Revision    : 1.0 - initial release
//==============================================================================
package ir_key_pkg;

    // Event type codes carried in evt_data[7:6]
    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_REPEAT  = 2'b01;
    localparam logic [1:0] EVT_RELEASE = 2'b10;

    // evt_data field layout
    localparam int EVT_W        = 8;
    localparam int EVT_TYPE_MSB = 7;
    localparam int EVT_TYPE_LSB = 6;
    localparam int EVT_KEY_MSB  = 3;
    localparam int EVT_KEY_LSB  = 0;
    localparam int KEY_W        = 4;
    localparam int CODE_W       = 16;

    // Key lookup FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PUSH = 2'd2
    } ir_state_e;

    // Pack an event byte; the reserved bits [5:4] are always zero.
    function automatic logic [EVT_W-1:0] mk_evt(input logic [1:0]       typ,
                                                input logic [KEY_W-1:0] key);
        logic [EVT_W-1:0] e;
        e = '0;
        e[EVT_TYPE_MSB:EVT_TYPE_LSB] = typ;
        e[EVT_KEY_MSB:EVT_KEY_LSB]   = key;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ir_evt_fifo.sv
`default_nettype none
//==============================================================================
// Module      : ir_evt_fifo
// Description : Show-ahead synchronous FIFO. The head entry is presented on
//               data_o whenever the FIFO is not empty (zero when empty).
//               A push while full is accepted only if a pop happens in the
//               same cycle; a pop while empty is ignored.
// Revision    : 1.0 - initial release
// Ports       : clk_i   - clock (rising edge)
//               rst_ni  - asynchronous active-low reset
//               push_i  - write data_i
//               data_i  - write data
//               pop_i   - discard head entry
//               data_o  - head entry
//               full_o  - FIFO full
//               empty_o - FIFO empty
//==============================================================================
module ir_evt_fifo #(
    parameter int DEPTH = 8,    // power of two, >= 2
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty; power-of-two
    // depth makes the wrap implicit.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_pop;
    logic             w_push;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign w_pop  = pop_i && !empty_o;
    // When full, the slot being written is the head being popped this cycle,
    // which is read before the edge, so both can proceed.
    assign w_push = push_i && (!full_o || w_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/ir_key_evt.sv
`default_nettype none
//==============================================================================
// Module      : ir_key_evt
// Description : Converts decoded IR frames into key events. A new frame is
//               looked up in a writable key table (one entry per cycle);
//               a hit pushes a press event. Receiver repeat counts produce
//               repeat events for the last key. Events are queued in a
//               show-ahead FIFO with a sticky overflow flag.
// Revision    : 1.0 - initial release
// Build macro : IR_KEY_RELEASE_EVT_EN - when defined, ir_code falling to 0
//               with a valid last key pushes a release event.
// Ports       : clk27       - clock            reset_n     - async reset, low
//               ir_code     - {addr, cmd}      ir_code_ack - new frame pulse
//               ir_code_cnt - frame/repeat count
//               tbl_we/tbl_addr/tbl_wdata - key table write port
//               evt_rd      - pop event        evt_data    - event head
//               evt_valid   - event available  evt_ovf     - sticky overflow
//               evt_ovf_clr - clear overflow
//==============================================================================
module ir_key_evt
    import ir_key_pkg::*;
#(
    parameter int NUM_KEYS   = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int RPT_DELAY  = 6,
    parameter int RPT_RATE   = 2
) (
    input  logic                clk27,
    input  logic                reset_n,
    input  logic [CODE_W-1:0]   ir_code,
    input  logic                ir_code_ack,
    input  logic [7:0]          ir_code_cnt,
    input  logic                tbl_we,
    input  logic [KEY_W-1:0]    tbl_addr,
    input  logic [CODE_W-1:0]   tbl_wdata,
    input  logic                evt_rd,
    output logic [EVT_W-1:0]    evt_data,
    output logic                evt_valid,
    output logic                evt_ovf,
    input  logic                evt_ovf_clr
);

    localparam logic [KEY_W-1:0] C_LAST_IDX  = KEY_W'(NUM_KEYS - 1);
    localparam logic [7:0]       C_RPT_DELAY = 8'(RPT_DELAY);
    localparam logic [7:0]       C_RPT_RATE  = 8'(RPT_RATE);

    // Key table
    logic [CODE_W-1:0] tbl_q [NUM_KEYS];

    // Lookup FSM and key tracking
    ir_state_e         state_q;
    logic [CODE_W-1:0] scan_code_q;
    logic [KEY_W-1:0]  idx_q;
    logic [KEY_W-1:0]  last_key_q;
    logic              last_key_vld_q;

    // Input history for edge/change detection
    logic [CODE_W-1:0] code_prev_q;
    logic [7:0]        cnt_prev_q;

    logic              ovf_q;

    logic              w_hit;
    logic              w_code_fall;
    logic              w_cnt_chg;
    logic [7:0]        w_cnt_off;
    logic              w_rpt_slot;
    logic              w_rpt_evt;
    logic              w_rel_evt;
    logic              w_push;
    logic [EVT_W-1:0]  w_evt;
    logic              w_full;
    logic              w_empty;

    //--------------------------------------------------------------------------
    // Key table: writes during a scan are seen from the next compare cycle
    // because the compare reads the table combinationally.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_KEYS; i++) tbl_q[i] <= '0;
        end else if (tbl_we && (int'(tbl_addr) < NUM_KEYS)) begin
            tbl_q[tbl_addr] <= tbl_wdata;
        end
    end

    // Empty entries are unprogrammed and must never match.
    assign w_hit = (tbl_q[idx_q] != '0) && (tbl_q[idx_q] == scan_code_q);

    //--------------------------------------------------------------------------
    // Repeat / release detection
    //--------------------------------------------------------------------------
    assign w_code_fall = (code_prev_q != '0) && (ir_code == '0);
    assign w_cnt_chg   = (ir_code_cnt != cnt_prev_q);
    assign w_cnt_off   = ir_code_cnt - C_RPT_DELAY;
    assign w_rpt_slot  = (ir_code_cnt >= C_RPT_DELAY) &&
                         ((w_cnt_off % C_RPT_RATE) == 8'd0);

    // A count change that coincides with a new frame belongs to that frame.
    assign w_rpt_evt = w_cnt_chg && w_rpt_slot && (ir_code != '0) &&
                       last_key_vld_q && (state_q == ST_IDLE) && !ir_code_ack;

`ifdef IR_KEY_RELEASE_EVT_EN
    // A release racing a press in PUSH is dropped: the new press owns last_key.
    assign w_rel_evt = w_code_fall && last_key_vld_q && (state_q != ST_PUSH);
`else
    assign w_rel_evt = 1'b0;
`endif

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            code_prev_q <= '0;
            cnt_prev_q  <= '0;
        end else begin
            code_prev_q <= ir_code;
            cnt_prev_q  <= ir_code_cnt;
        end
    end

    //--------------------------------------------------------------------------
    // Lookup FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            scan_code_q    <= '0;
            idx_q          <= '0;
            last_key_q     <= '0;
            last_key_vld_q <= 1'b0;
        end else begin
            // Key released; a press completing this cycle overrides below.
            if (w_code_fall) last_key_vld_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (ir_code_ack) begin
                        scan_code_q <= ir_code;
                        idx_q       <= '0;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_hit) begin
                        state_q <= ST_PUSH;
                    end else if (idx_q == C_LAST_IDX) begin
                        last_key_vld_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                ST_PUSH: begin
                    last_key_q     <= idx_q;
                    last_key_vld_q <= 1'b1;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Event source select. Press only occurs outside IDLE and repeat only in
    // IDLE; repeat needs ir_code != 0 while release needs ir_code == 0, so
    // the sources never collide.
    //--------------------------------------------------------------------------
    always_comb begin
        w_push = 1'b0;
        w_evt  = '0;
        if (state_q == ST_PUSH) begin
            w_push = 1'b1;
            w_evt  = mk_evt(EVT_PRESS, idx_q);
        end else if (w_rpt_evt) begin
            w_push = 1'b1;
            w_evt  = mk_evt(EVT_REPEAT, last_key_q);
        end else if (w_rel_evt) begin
            w_push = 1'b1;
            w_evt  = mk_evt(EVT_RELEASE, last_key_q);
        end
    end

    //--------------------------------------------------------------------------
    // Event FIFO and overflow flag
    //--------------------------------------------------------------------------
    ir_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_i   (clk27),
        .rst_ni  (reset_n),
        .push_i  (w_push),
        .data_i  (w_evt),
        .pop_i   (evt_rd),
        .data_o  (evt_data),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign evt_valid = !w_empty;

    // A pop in the same cycle makes room, so only an unmatched push overflows.
    // Setting wins over clearing.
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else if (w_push && w_full && !evt_rd) begin
            ovf_q <= 1'b1;
        end else if (evt_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign evt_ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_ir_key_evt.sv
`default_nettype none
//==============================================================================
// Module      : tb_ir_key_evt
// Description : Self-checking bench for ir_key_evt. Directed checks for
//               latency, overflow and reset; a scoreboard with a key-level
//               reference model for repeat/release and random traffic.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ir_key_evt;

    localparam int NK = 16;
    localparam int FD = 8;
    localparam int RD = 6;
    localparam int RR = 2;

    logic        clk27       = 1'b0;
    logic        reset_n     = 1'b0;
    logic [15:0] ir_code     = '0;
    logic        ir_code_ack = 1'b0;
    logic [7:0]  ir_code_cnt = '0;
    logic        tbl_we      = 1'b0;
    logic [3:0]  tbl_addr    = '0;
    logic [15:0] tbl_wdata   = '0;
    logic        evt_rd      = 1'b0;
    logic        evt_ovf_clr = 1'b0;
    logic [7:0]  evt_data;
    logic        evt_valid;
    logic        evt_ovf;

    ir_key_evt #(
        .NUM_KEYS   (NK),
        .FIFO_DEPTH (FD),
        .RPT_DELAY  (RD),
        .RPT_RATE   (RR)
    ) dut (
        .clk27       (clk27),
        .reset_n     (reset_n),
        .ir_code     (ir_code),
        .ir_code_ack (ir_code_ack),
        .ir_code_cnt (ir_code_cnt),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_wdata   (tbl_wdata),
        .evt_rd      (evt_rd),
        .evt_data    (evt_data),
        .evt_valid   (evt_valid),
        .evt_ovf     (evt_ovf),
        .evt_ovf_clr (evt_ovf_clr)
    );

    always #5 clk27 = ~clk27;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  exp_q[$];
    bit          auto_pop = 1'b0;
    bit          man_rd   = 1'b0;

    // Reference model state (key level, no cycle timing)
    logic [15:0] m_tbl [NK];
    int          m_last = 0;
    bit          m_vld  = 1'b0;
    logic [15:0] m_code = '0;
    int          m_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk27);
            #1;
        end
    endtask

    function automatic logic [7:0] ev(input int typ, input int key);
        return 8'(typ * 64 + key);
    endfunction

    function automatic int m_lookup(input logic [15:0] c);
        for (int i = 0; i < NK; i++)
            if (m_tbl[i] != 16'h0 && m_tbl[i] == c) return i;
        return -1;
    endfunction

    // Monitor: drains and checks events against the scoreboard when enabled,
    // otherwise forwards the manual read request.
    initial begin
        forever begin
            @(negedge clk27);
            if (auto_pop) begin
                if (evt_valid) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got %02h, expected no event", evt_data);
                    end else begin
                        chk("sb_event", 32'(evt_data), 32'(exp_q.pop_front()));
                    end
                    evt_rd = 1'b1;
                end else begin
                    evt_rd = 1'b0;
                end
            end else begin
                evt_rd = man_rd;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        for (int i = 0; i < NK; i++) m_tbl[i] = '0;
        m_vld  = 1'b0;
        m_code = ir_code;
        m_cnt  = int'(ir_code_cnt);
    endtask

    task automatic tbl_write(input int idx, input logic [15:0] c);
        tbl_we    = 1'b1;
        tbl_addr  = 4'(idx);
        tbl_wdata = c;
        tick(1);
        tbl_we    = 1'b0;
        m_tbl[idx] = c;
    endtask

    task automatic pop_one();
        man_rd = 1'b1;
        tick(1);
        man_rd = 1'b0;
    endtask

    // Frame and count cycles until evt_valid (bounded).
    task automatic press_lat(input logic [15:0] c, output int lat);
        ir_code     = c;
        ir_code_ack = 1'b1;
        ir_code_cnt = 8'd1;
        tick(1);
        ir_code_ack = 1'b0;
        lat = 1;
        while (!evt_valid && lat < 30) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic press_raw(input logic [15:0] c);
        ir_code     = c;
        ir_code_ack = 1'b1;
        ir_code_cnt = 8'd1;
        tick(1);
        ir_code_ack = 1'b0;
        tick(20);
    endtask

    // Model-tracked stimulus (scoreboard phase)
    task automatic press(input logic [15:0] c);
        int k;
        k = m_lookup(c);
        if (k >= 0) begin
            exp_q.push_back(ev(0, k));
            m_last = k;
            m_vld  = 1'b1;
        end else begin
            m_vld = 1'b0;
        end
        m_code = c;
        m_cnt  = 1;
        press_raw(c);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            if (m_cnt < 240) begin
                m_cnt++;
                ir_code_cnt = 8'(m_cnt);
                if (m_cnt >= RD && ((m_cnt - RD) % RR) == 0 && m_code != 16'h0 && m_vld)
                    exp_q.push_back(ev(1, m_last));
                tick(1);
            end
        end
    endtask

    task automatic release_key();
        if (m_code != 16'h0) begin
`ifdef IR_KEY_RELEASE_EVT_EN
            if (m_vld) exp_q.push_back(ev(2, m_last));
`endif
            m_vld = 1'b0;
        end
        ir_code     = 16'h0;
        ir_code_cnt = 8'd0;
        m_code      = 16'h0;
        m_cnt       = 0;
        tick(3);
    endtask

    initial begin
        int          lat;
        logic [15:0] c;
        int          idx;

        //---------------- Directed phase (manual reads) ----------------
        tick(1);
        chk("rst_evt_valid", 32'(evt_valid), 32'h0);
        chk("rst_evt_data",  32'(evt_data),  32'h0);
        chk("rst_evt_ovf",   32'(evt_ovf),   32'h0);
        do_reset();

        // Press latency, index 5 and worst case index 15
        tbl_write(5, 16'h20DF);
        press_lat(16'h20DF, lat);
        chk("press5_lat_le18", 32'(lat <= 18), 32'h1);
        chk("press5_valid", 32'(evt_valid), 32'h1);
        chk("press5_data", 32'(evt_data), 32'h05);
        pop_one();
        chk("press5_popped", 32'(evt_valid), 32'h0);

        tbl_write(15, 16'hA55A);
        press_lat(16'hA55A, lat);
        chk("press15_lat_le18", 32'(lat <= 18), 32'h1);
        chk("press15_data", 32'(evt_data), 32'h0F);
        pop_one();

        // Overflow: 9 presses into 8 entries
        for (int i = 0; i < 9; i++) tbl_write(i, 16'h1000 + 16'(i));
        for (int i = 0; i < 9; i++) press_raw(16'h1000 + 16'(i));
        chk("ovf_set", 32'(evt_ovf), 32'h1);
        chk("ovf_head", 32'(evt_data), 32'h00);
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;
        chk("ovf_clr", 32'(evt_ovf), 32'h0);

        // Full FIFO: repeat push (last key 8) together with pop
        ir_code_cnt = 8'd5;
        tick(1);
        ir_code_cnt = 8'd6;
        man_rd = 1'b1;
        tick(1);
        man_rd = 1'b0;
        chk("full_pop_push_no_ovf", 32'(evt_ovf), 32'h0);
        chk("full_pop_push_head", 32'(evt_data), 32'h01);

        // Clear coinciding with a new overflow leaves the flag set
        ir_code_cnt = 8'd7;
        tick(1);
        ir_code_cnt = 8'd8;
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;
        chk("ovf_clr_vs_set", 32'(evt_ovf), 32'h1);
        evt_ovf_clr = 1'b1;
        tick(1);
        evt_ovf_clr = 1'b0;

        for (int i = 1; i < 8; i++) begin
            chk("drain_order", 32'(evt_data), 32'(i));
            pop_one();
        end
        chk("drain_repeat", 32'(evt_data), 32'h48);
        pop_one();
        chk("drain_empty", 32'(evt_valid), 32'h0);
        pop_one();
        chk("empty_pop_valid", 32'(evt_valid), 32'h0);
        chk("empty_pop_data", 32'(evt_data), 32'h0);
        press_lat(16'h1002, lat);
        chk("after_wrap_data", 32'(evt_data), 32'h02);
        pop_one();

        // Reset in the middle of a scan
        tbl_write(10, 16'hBEEF);
        ir_code     = 16'hBEEF;
        ir_code_ack = 1'b1;
        tick(1);
        ir_code_ack = 1'b0;
        tick(3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(evt_valid), 32'h0);
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < NK; i++) m_tbl[i] = '0;
        tick(20);
        chk("rst_scan_no_evt", 32'(evt_valid), 32'h0);
        press_lat(16'hBEEF, lat);
        chk("rst_tbl_cleared", 32'(evt_valid), 32'h0);
        tbl_write(10, 16'hBEEF);
        press_lat(16'hBEEF, lat);
        chk("rst_recover_data", 32'(evt_data), 32'h0A);
        pop_one();

        //---------------- Scoreboard phase ----------------
        ir_code     = 16'h0;
        ir_code_cnt = 8'd0;
        do_reset();
        auto_pop = 1'b1;

        // Held key, count 1..10: repeats at 6, 8, 10
        tbl_write(5, 16'h20DF);
        press(16'h20DF);
        for (int cv = 2; cv <= 10; cv++) begin
            ir_code_cnt = 8'(cv);
            if (cv == 6 || cv == 8 || cv == 10) exp_q.push_back(8'h45);
            tick(1);
        end
        m_cnt = 10;
        tick(3);

        // Unknown code: no press and no later repeats
        press(16'h1234);
        chk("unknown_no_valid", 32'(evt_valid), 32'h0);
        steps(10);

        // Release (event only with the release build)
        press(16'h20DF);
        steps(6);
        release_key();
        steps(8);

        // Random table with a duplicate code, then random traffic
        for (int i = 0; i < NK; i++) begin
            c = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
            tbl_write(i, c);
        end
        tbl_write(3, 16'h7E57);
        tbl_write(12, 16'h7E57);
        for (int op = 0; op < 40; op++) begin
            case ($urandom_range(0, 4))
                0: begin
                    idx = int'($urandom_range(0, NK - 1));
                    if (m_tbl[idx] != 16'h0) press(m_tbl[idx]);
                    else press(16'h7E57);
                end
                1: begin
                    c = 16'($urandom_range(1, 65535));
                    while (m_lookup(c) >= 0) c = c + 16'd1;
                    if (c == 16'h0) c = 16'h0001;
                    press(c);
                end
                2: steps(int'($urandom_range(1, 12)));
                3: release_key();
                default: tbl_write(int'($urandom_range(0, NK - 1)),
                                   16'($urandom_range(0, 65535)));
            endcase
        end
        release_key();
        tick(30);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ir_key_evt.md
IR_KEY_EVT -- requirements
Module: ir_key_evt

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 16: key table entries; key index is 4 bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries, power of two.
REQ-003 SHALL have parameter RPT_DELAY, default 6: first ir_code_cnt value that emits a repeat event.
REQ-004 SHALL have parameter RPT_RATE, default 2: repeat-event spacing in ir_code_cnt steps, at least 1.
REQ-005 SHALL have port clk27  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port ir_code  in  16  decoded {address, command} from the IR receiver; 0 means no key held.
REQ-008 SHALL have port ir_code_ack  in  1  one-cycle pulse: new valid frame on ir_code.
REQ-009 SHALL have port ir_code_cnt  in  8  receiver frame/repeat count; 1 on a new frame, +1 per repeat, 0 on release.
REQ-010 SHALL have port tbl_we  in  1  key table write strobe.
REQ-011 SHALL have port tbl_addr  in  4  key table index.
REQ-012 SHALL have port tbl_wdata  in  16  IR code for that index.
REQ-013 SHALL have port evt_rd  in  1  pop the FIFO head.
REQ-014 SHALL have port evt_data  out  8  FIFO head, show-ahead: [7:6] type (00 press, 01 repeat, 10 release), [5:4] zero, [3:0] key index.
REQ-015 SHALL have port evt_valid  out  1  FIFO not empty.
REQ-016 SHALL have port evt_ovf  out  1  sticky overflow flag.
REQ-017 SHALL have port evt_ovf_clr  in  1  clears evt_ovf.

Function
REQ-018 SHALL use FSM states IDLE, SCAN and PUSH; IDLE->SCAN on ir_code_ack, latching ir_code into scan_code.
REQ-019 SCAN SHALL compare one table entry per cycle, index 0 upward; first match -> PUSH; no match after NUM_KEYS cycles -> IDLE, no event, last_key_vld cleared.
REQ-020 Table entries equal to 16'h0000 SHALL never match.
REQ-021 PUSH SHALL enqueue a press event with the matched index, store it in last_key, set last_key_vld and return to IDLE; worst-case ack-to-evt_valid latency is NUM_KEYS+2 cycles.
REQ-022 ir_code_ack arriving outside IDLE SHALL be dropped.
REQ-023 A change of ir_code_cnt to value n >= RPT_DELAY with (n-RPT_DELAY) mod RPT_RATE == 0, ir_code != 0, last_key_vld=1 and FSM in IDLE SHALL enqueue a repeat event for last_key.
REQ-024 A cnt change coinciding with ir_code_ack SHALL be treated as a new frame only.
REQ-025 A table write during SCAN SHALL take effect from the next compare cycle.
REQ-026 FIFO push when full SHALL drop the event and set evt_ovf; a simultaneous push and pop when full SHALL both succeed, with no overflow.
REQ-027 evt_rd while empty SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 evt_ovf_clr together with a new overflow SHALL leave evt_ovf set.

Reset
REQ-029 reset_n low SHALL immediately force: FSM to IDLE; FIFO empty; evt_valid=0; evt_data=0; evt_ovf=0; last_key_vld=0; all table entries to 0.
REQ-030 A reset during SCAN or PUSH SHALL lose the pending event, with no partial push.

Configuration
REQ-031 With IR_KEY_RELEASE_EVT_EN defined, an ir_code transition from nonzero to 0 while last_key_vld=1 SHALL enqueue a release event for last_key and clear last_key_vld.
REQ-032 Without IR_KEY_RELEASE_EVT_EN, no release event SHALL be generated, and that transition SHALL only clear last_key_vld.

Structure
REQ-033 Package ir_key_pkg SHALL hold the event type constants (press, repeat, release), the evt_data field positions and the FSM state encoding.
REQ-034 The FIFO SHALL be sub-module ir_evt_fifo (parameterised depth/width, show-ahead, full/empty, push/pop); the key table and FSM SHALL stay in ir_key_evt.

Verification
REQ-035 Table[5]=16'h20DF, ack with ir_code=16'h20DF -> press 8'h05 within 18 cycles, evt_valid=1.
REQ-036 Held key, ir_code_cnt steps 1..10, defaults -> repeat 8'h45 at cnt 6, 8 and 10 only.
REQ-037 Ack with a code not in the table -> no event, evt_valid stays 0, later cnt steps give no repeats.
REQ-038 9 presses without evt_rd -> 8 events in order, evt_ovf=1; evt_ovf_clr -> 0; pop+push when full -> no overflow.
REQ-039 With IR_KEY_RELEASE_EVT_EN, ir_code 16'h20DF->0 -> release 8'h85; without the macro -> no event.
REQ-040 reset_n pulsed mid-SCAN -> no event, table reads 0, FSM in IDLE.
